// File: rtl/scope_trig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_trig_pkg
// Purpose  : Shared definitions for the scope trigger/capture path.
//            - acquisition state encoding
//            - bit indices into the 5-bit trigger-control register
// Revision : 1.0 - initial release
// ============================================================================
package scope_trig_pkg;

    // Acquisition sequencer states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // trig_ctrl bit positions
    localparam int TC_SLOPE = 0;  // 1 = rising, 0 = falling
    localparam int TC_AUTO  = 1;  // auto-trigger enable
    localparam int TC_ARM   = 2;  // rising edge starts a capture
    localparam int TC_ABORT = 3;  // level-sensitive abort
    localparam int TC_FORCE = 4;  // rising edge forces a trigger

endpackage
`default_nettype wire

// File: rtl/scope_edge_cmp.sv
`default_nettype none
// ============================================================================
// Module   : scope_edge_cmp
// Purpose  : Holds the previously accepted sample and compares it with the
//            current sample against a threshold to detect a slope crossing.
// Ports    : clk, reset_n      - clock, async active-low reset
//            update            - load cur into the previous-sample register
//            cur               - current sample
//            level             - threshold (unsigned)
//            slope             - 1 = rising crossing, 0 = falling crossing
//            hit               - combinational crossing indication for cur
// Revision : 1.0 - initial release
// ============================================================================
module scope_edge_cmp #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              update,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    output logic              hit
);

    logic [DATA_W-1:0] r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else if (update) begin
            r_prev <= cur;
        end
    end

    // Crossing is judged between the stored sample and the one on the bus now
    always_comb begin
        if (slope) begin
            hit = (r_prev < level) && (cur >= level);
        end else begin
            hit = (r_prev > level) && (cur <= level);
        end
    end

endmodule
`default_nettype wire

// File: rtl/scope_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : scope_trig_capture
// Purpose  : Trigger detector and acquisition sequencer. Writes pre- and
//            post-trigger ADC samples into a circular capture RAM and reports
//            status / trigger address to the CPU.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            trig_ctrl[4:0]               - slope/auto/arm/abort/force
//            trig_level                   - trigger threshold
//            post_cnt                     - post-trigger sample count
//            sample_valid, sample_data    - ADC sample stream
//            wr_en, wr_addr, wr_data      - capture RAM write port
//            trig_addr                    - RAM address of trigger sample
//            busy, triggered, done, irq   - status
// Revision : 1.0 - initial release
// ============================================================================
module scope_trig_capture
    import scope_trig_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int AUTO_TO = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        trig_ctrl,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] post_cnt,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic              irq
);

    localparam int                AUTO_W      = $clog2(AUTO_TO + 1);
    localparam logic [AUTO_W-1:0] C_AUTO_LAST = AUTO_W'(AUTO_TO - 1);
    localparam logic [AUTO_W-1:0] C_AUTO_MAX  = AUTO_W'(AUTO_TO);
    localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_arm_q;
    logic              r_force_q;
    logic              r_force_pend;
    logic [ADDR_W-1:0] r_cnt;        // prefill / post countdown
    logic [ADDR_W-1:0] r_post;       // post_cnt captured at arm
    logic [AUTO_W-1:0] r_auto;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic              r_triggered;
    logic              r_irq;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0] w_post_nxt;
    logic [AUTO_W-1:0] w_auto_nxt;
    logic              w_force_pend_nxt;
    logic [ADDR_W-1:0] w_trig_addr_nxt;
    logic              w_triggered_nxt;
    logic              w_irq_nxt;

    logic              w_arm_rise;
    logic              w_force_rise;
    logic              w_abort;
    logic              w_capturing;
    logic              w_accept;
    logic [ADDR_W-1:0] w_post_eff;
    logic [ADDR_W-1:0] w_pre_need;
    logic              w_slope_hit;
    logic              w_auto_hit;
    logic              w_hit;

    assign w_arm_rise   = trig_ctrl[TC_ARM]   & ~r_arm_q;
    assign w_force_rise = trig_ctrl[TC_FORCE] & ~r_force_q;
    assign w_abort      = trig_ctrl[TC_ABORT];
    assign w_capturing  = (r_state == ST_PREFILL) || (r_state == ST_WAIT_TRIG) ||
                          (r_state == ST_POST);
    assign w_accept     = sample_valid & w_capturing & ~w_abort;

    // A post count of 0 behaves as 1; the prefill length is DEPTH - post,
    // which in ADDR_W-bit arithmetic is simply the two's complement.
    assign w_post_eff   = (post_cnt == '0) ? C_ONE : post_cnt;
    assign w_pre_need   = '0 - w_post_eff;

    assign w_auto_hit   = trig_ctrl[TC_AUTO] && (r_auto >= C_AUTO_LAST);
    assign w_hit        = (r_state == ST_WAIT_TRIG) && sample_valid &&
                          (w_slope_hit || w_force_rise || r_force_pend || w_auto_hit);

    scope_edge_cmp #(
        .DATA_W (DATA_W)
    ) u_edge_cmp (
        .clk     (clk),
        .reset_n (reset_n),
        .update  (w_accept),
        .cur     (sample_data),
        .level   (trig_level),
        .slope   (trig_ctrl[TC_SLOPE]),
        .hit     (w_slope_hit)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_post_nxt       = r_post;
        w_auto_nxt       = r_auto;
        w_force_pend_nxt = r_force_pend;
        w_trig_addr_nxt  = r_trig_addr;
        w_triggered_nxt  = r_triggered;
        w_irq_nxt        = 1'b0;

        if (w_abort) begin
            // Abort overrides arm, hit and completion in the same cycle
            w_state_nxt      = ST_IDLE;
            w_triggered_nxt  = 1'b0;
            w_force_pend_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_arm_rise) begin
                        w_state_nxt     = ST_PREFILL;
                        w_cnt_nxt       = w_pre_need;
                        w_post_nxt      = w_post_eff;
                        w_triggered_nxt = 1'b0;
                    end
                end
                ST_PREFILL: begin
                    if (sample_valid) begin
                        if (r_cnt == C_ONE) begin
                            w_state_nxt      = ST_WAIT_TRIG;
                            w_auto_nxt       = '0;
                            w_force_pend_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt - C_ONE;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (sample_valid) begin
                        w_force_pend_nxt = 1'b0;
                        if (w_hit) begin
                            w_trig_addr_nxt = r_ptr;
                            w_triggered_nxt = 1'b1;
                            if (r_post == C_ONE) begin
                                // Trigger sample alone satisfies the post count
                                w_state_nxt = ST_DONE;
                                w_irq_nxt   = 1'b1;
                            end else begin
                                w_cnt_nxt   = r_post - C_ONE;
                                w_state_nxt = ST_POST;
                            end
                        end else if (r_auto != C_AUTO_MAX) begin
                            w_auto_nxt = r_auto + AUTO_W'(1);
                        end
                    end else if (w_force_rise) begin
                        // Hold the force request until the next sample arrives
                        w_force_pend_nxt = 1'b1;
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        if (r_cnt == C_ONE) begin
                            w_state_nxt = ST_DONE;
                            w_irq_nxt   = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - C_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_arm_q      <= 1'b0;
            r_force_q    <= 1'b0;
            r_force_pend <= 1'b0;
            r_cnt        <= '0;
            r_post       <= '0;
            r_auto       <= '0;
            r_trig_addr  <= '0;
            r_triggered  <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_arm_q      <= trig_ctrl[TC_ARM];
            r_force_q    <= trig_ctrl[TC_FORCE];
            r_force_pend <= w_force_pend_nxt;
            r_cnt        <= w_cnt_nxt;
            r_post       <= w_post_nxt;
            r_auto       <= w_auto_nxt;
            r_trig_addr  <= w_trig_addr_nxt;
            r_triggered  <= w_triggered_nxt;
            r_irq        <= w_irq_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Capture RAM write path; pointer free-runs modulo DEPTH
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= sample_data;
                r_ptr     <= r_ptr + C_ONE;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign triggered = r_triggered;
    assign irq       = r_irq;
    assign busy      = w_capturing;
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_scope_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_scope_trig_capture
// Purpose  : Directed self-checking bench for scope_trig_capture
//            (ADDR_W 10, DATA_W 8, AUTO_TO 100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scope_trig_capture;
    import scope_trig_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] trig_ctrl;
    logic [7:0] trig_level;
    logic [9:0] post_cnt;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] trig_addr;
    logic       busy;
    logic       triggered;
    logic       done;
    logic       irq;

    int checks = 0;
    int errors = 0;

    // Write/irq monitor state
    logic [7:0] mem [1024];
    int         wr_cnt  = 0;
    int         irq_cnt = 0;
    logic [9:0] last_addr;

    scope_trig_capture #(
        .ADDR_W  (10),
        .DATA_W  (8),
        .AUTO_TO (100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trig_ctrl    (trig_ctrl),
        .trig_level   (trig_level),
        .post_cnt     (post_cnt),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .trig_addr    (trig_addr),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            mem[wr_addr] = wr_data;
            last_addr    = wr_addr;
            wr_cnt++;
        end
        if (irq === 1'b1) irq_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input logic [4:0] base, input logic [9:0] pc);
        post_cnt  = pc;
        trig_ctrl = base | 5'b00100;
        @(negedge clk);
        trig_ctrl = base;
    endtask

    logic [7:0] seq2 [6];
    int n, k, w0, w5;

    initial begin
        seq2 = '{8'h50, 8'h70, 8'h60, 8'h50, 8'h41, 8'h40};
        reset_n      = 1'b0;
        trig_ctrl    = 5'b0;
        trig_level   = 8'h0;
        post_cnt     = 10'd0;
        sample_valid = 1'b0;
        sample_data  = 8'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- reset state ----------------
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_wren", wr_en, 0);
        chk("rst_irq", irq, 0);
        chk("rst_taddr", trig_addr, 0);

        // ---------------- 1: rising ramp ----------------
        trig_level = 8'h80;
        arm(5'b00001, 10'd16);
        chk("t1_busy_arm", busy, 1);
        w0 = wr_cnt;
        for (int i = 0; i < 1007; i++) send(8'(i));
        chk("t1_prefill_1007", 32'(dut.r_state), 32'(ST_PREFILL));
        send(8'(1007));
        chk("t1_wait_1008", 32'(dut.r_state), 32'(ST_WAIT_TRIG));
        chk("t1_no_trig_yet", triggered, 0);
        n = 1008;
        while (triggered !== 1'b1 && n < 1400) begin
            send(8'(n));
            n++;
        end
        chk("t1_hit_count", n, 1153);
        chk("t1_taddr", trig_addr, 128);
        chk("t1_trig_data", mem[128], 8'h80);
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            send(8'(n));
            n++;
            k++;
        end
        chk("t1_post_after_hit", k, 15);
        chk("t1_total_writes", wr_cnt - w0, 1168);
        chk("t1_busy_done", busy, 0);
        chk("t1_irq_cnt", irq_cnt, 1);
        idle(2);
        chk("t1_irq_low", irq, 0);
        w0 = wr_cnt;
        send(8'h11); send(8'h22);
        chk("t1_drop_in_done", wr_cnt - w0, 0);
        chk("t1_done_held", done, 1);
        chk("t1_irq_once", irq_cnt, 1);

        // ---------------- 2: falling slope ----------------
        trig_level = 8'h40;
        arm(5'b00000, 10'd4);
        chk("t2_done_clr", done, 0);
        chk("t2_trig_clr", triggered, 0);
        for (int i = 0; i < 1020; i++) send(8'h30);
        chk("t2_wait", 32'(dut.r_state), 32'(ST_WAIT_TRIG));
        for (int i = 0; i < 5; i++) send(seq2[i]);
        chk("t2_no_rise_trig", triggered, 0);
        send(seq2[5]);
        chk("t2_trig", triggered, 1);
        chk("t2_taddr", trig_addr, 145);
        chk("t2_trig_data", mem[145], 8'h40);
        send(8'h30); send(8'h30);
        chk("t2_not_done", done, 0);
        send(8'h30);
        chk("t2_done", done, 1);
        chk("t2_irq_cnt", irq_cnt, 2);

        // ---------------- 3: auto trigger ----------------
        trig_level = 8'h80;
        arm(5'b00011, 10'd8);
        for (int i = 0; i < 1016; i++) send(8'h10);
        for (int i = 0; i < 99; i++) send(8'h10);
        chk("t3_no_trig_99", triggered, 0);
        send(8'h10);
        chk("t3_trig_100", triggered, 1);
        chk("t3_taddr", trig_addr, 240);
        for (int i = 0; i < 7; i++) send(8'h10);
        chk("t3_done", done, 1);
        chk("t3_irq_cnt", irq_cnt, 3);

        // ---------------- 4: force trigger ----------------
        arm(5'b00001, 10'd2);
        for (int i = 0; i < 1072; i++) send(8'h10);
        chk("t4_busy_no_force", busy, 1);
        chk("t4_no_trig", triggered, 0);
        trig_ctrl = 5'b10001;
        @(negedge clk);
        trig_ctrl = 5'b00001;
        idle(2);
        chk("t4_latched_only", triggered, 0);
        send(8'h10);
        chk("t4_trig", triggered, 1);
        chk("t4_taddr", trig_addr, 296);
        send(8'h10);
        chk("t4_done", done, 1);
        chk("t4_irq_cnt", irq_cnt, 4);

        // ---------------- 5: abort in POST ----------------
        arm(5'b00001, 10'd4);
        for (int i = 0; i < 1020; i++) send(8'h10);
        send(8'h90);
        chk("t5_taddr", trig_addr, 294);
        chk("t5_post", 32'(dut.r_state), 32'(ST_POST));
        w5 = wr_cnt;
        trig_ctrl = 5'b01001;
        send(8'h95);
        trig_ctrl = 5'b00001;
        chk("t5_no_write", wr_cnt - w5, 0);
        chk("t5_idle", 32'(dut.r_state), 32'(ST_IDLE));
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_trig", triggered, 0);
        send(8'h90); send(8'h90);
        chk("t5_idle_drop", wr_cnt - w5, 0);
        chk("t5_no_irq", irq_cnt, 4);

        // ---------------- 6: pointer wrap, arm while busy ----------------
        // Partial aborted capture moves the pointer from 295 to 1020
        arm(5'b00001, 10'd10);
        for (int i = 0; i < 725; i++) send(8'h10);
        trig_ctrl = 5'b01001;
        idle(1);
        trig_ctrl = 5'b00001;
        idle(1);
        arm(5'b00001, 10'd10);
        for (int i = 0; i < 4; i++) send(8'h10);
        chk("t6_addr_1023", last_addr, 1023);
        send(8'h10);
        chk("t6_addr_wrap0", last_addr, 0);
        trig_ctrl = 5'b00101;
        send(8'h10);
        trig_ctrl = 5'b00001;
        chk("t6_rearm_ignored", 32'(dut.r_state), 32'(ST_PREFILL));
        for (int i = 0; i < 1007; i++) send(8'h10);
        chk("t6_prefill_1013", 32'(dut.r_state), 32'(ST_PREFILL));
        send(8'h10);
        chk("t6_wait_1014", 32'(dut.r_state), 32'(ST_WAIT_TRIG));
        send(8'h90);
        chk("t6_taddr", trig_addr, 1010);
        for (int i = 0; i < 9; i++) send(8'h10);
        chk("t6_done", done, 1);
        chk("t6_last_addr", last_addr, 1019);
        chk("t6_irq_cnt", irq_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scope_trig_capture.md
# scope_trig_capture

Trigger detector and acquisition sequencer for the scope sample path. Sits directly downstream of the 5-bit trigger-control PIO. It consumes that register's bits plus the ADC sample stream, finds the trigger edge, and writes pre- and post-trigger samples into a circular capture RAM. It also reports capture status and the trigger address back to the CPU through a status PIO and an interrupt line.

## Interface
Parameters:
- ADDR_W, 10 — capture RAM address width; DEPTH = 2**ADDR_W samples
- DATA_W, 8 — ADC sample width
- AUTO_TO, 65535 — auto-trigger timeout, in accepted samples

Ports:
- clk  in  1  system clock, single domain
- reset_n  in  1  asynchronous active-low reset
- trig_ctrl  in  5  trigger-control bits:
  - [0] slope: 1 = rising, 0 = falling
  - [1] auto-trigger enable
  - [2] arm: rising edge starts a capture
  - [3] abort: level-sensitive
  - [4] force trigger: rising edge
- trig_level  in  DATA_W  trigger threshold, unsigned
- post_cnt  in  ADDR_W  number of post-trigger samples, 1..DEPTH-1
- sample_valid  in  1  one-cycle qualifier for sample_data
- sample_data  in  DATA_W  ADC sample, unsigned
- wr_en  out  1  capture RAM write strobe
- wr_addr  out  ADDR_W  capture RAM write address
- wr_data  out  DATA_W  capture RAM write data
- trig_addr  out  ADDR_W  RAM address of the trigger sample
- busy  out  1  capture in progress
- triggered  out  1  trigger found in the current capture
- done  out  1  capture complete; held until next arm or abort
- irq  out  1  one-cycle pulse on entry to DONE

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- Reset values: state IDLE, all outputs 0, write pointer 0, edge-detect registers 0.
- arm_rise = trig_ctrl[2] & ~arm_q. force_rise is detected the same way from trig_ctrl[4].
- IDLE or DONE, on arm_rise:
  - enter PREFILL
  - clear done and triggered
  - set busy
  - load pre_need = DEPTH - post_cnt
  - write pointer keeps its current value; no clear needed
- Every state except IDLE and DONE, each sample_valid cycle:
  - wr_en = 1, wr_addr = pointer, wr_data = sample_data
  - pointer increments modulo DEPTH, wrapping DEPTH-1 -> 0
  - prev register updates to sample_data
- PREFILL: count accepted samples. Go to WAIT_TRIG on the cycle the pre_need-th sample is written. Trigger detection is disabled in this state.
- WAIT_TRIG: the current sample is a hit when any of the following holds:
  - rising slope: prev < trig_level and cur >= trig_level
  - falling slope: prev > trig_level and cur <= trig_level
  - force_rise is seen, latched until the next valid sample
  - auto enabled and the timeout counter reaches AUTO_TO
- On a hit, the hit sample is itself written:
  - trig_addr = its address
  - triggered = 1
  - post counter is loaded with post_cnt - 1
  - enter POST
- The first WAIT_TRIG sample compares against the last PREFILL sample held in prev.
- POST: decrement on each valid sample. When the sample that takes the counter to 0 is written: enter DONE, clear busy, set done, pulse irq. That is the post_cnt-th sample including the trigger sample.
- Abort (trig_ctrl[3] = 1) in any state: go to IDLE next cycle, clear busy, done, triggered, suppress wr_en that cycle, no irq. Abort has priority over arm, hit, and completion in the same cycle.
- arm_rise while busy is ignored.
- post_cnt = 0 is treated as 1. post_cnt and trig_level are sampled only at arm and on the hit respectively.

## Timing
- wr_en, wr_addr, and wr_data are registered: they appear 1 cycle after the qualifying sample_valid cycle.
- State, trig_addr, triggered, done, and irq update on the same edge as that sample's write, so they are consistent with wr_en.
- Back-to-back sample_valid is supported at full clock rate. Samples arriving in IDLE or DONE are dropped.
- Auto timeout counter: clears on entering WAIT_TRIG, counts valid samples, and saturates.

## Structure
- Shared package scope_trig_pkg holds:
  - state encoding localparams
  - trig_ctrl bit indices: TC_SLOPE = 0, TC_AUTO = 1, TC_ARM = 2, TC_ABORT = 3, TC_FORCE = 4
- One sub-module, scope_edge_cmp: registered prev sample plus the slope compare, producing a one-bit hit.

## Test plan
- Ramp 0..255 rising, level 0x80, slope 1, post_cnt 16, DEPTH 1024 → PREFILL writes 1008 samples, then:
  - trig_addr is the address of the sample holding 0x80
  - exactly 16 writes from the trigger sample, done = 1, irq pulses once
- Falling ramp with slope 0, level 0x40 → trigger on the first sample <= 0x40 whose previous sample was > 0x40. A rising crossing must not trigger.
- Constant 0x10 input, auto = 1, AUTO_TO = 100 → trigger on the 100th WAIT_TRIG sample, triggered = 1, capture completes.
- Constant input, auto = 0, force pulse mid-WAIT_TRIG → trigger on the next valid sample. With no force pulse, the block stays busy indefinitely.
- Abort asserted during POST and a trigger-crossing sample in the same cycle → IDLE next cycle, no write, done = 0, irq never asserted. A second arm then captures normally.
- Pointer starting at 1020 with post_cnt 10 → addresses wrap 1023 → 0. Arm pulse while busy → no restart.
